// File: rtl/cla_seq_adder_if.sv
// rtl/cla_seq_adder_if.sv - operand/result handshake bundle for cla_seq_adder
// Macro CLA_SUB_EN adds the op (subtract) signal.
interface cla_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SUB_EN
    logic             op;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
`ifdef CLA_SUB_EN
        output op,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
`ifdef CLA_SUB_EN
        input  op,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle WIDTH-bit adder time-sharing one 4-bit CLA slice
// Macro CLA_SUB_EN enables op=1 subtraction (a - b, cout=1 means no borrow).
module adder_4bit_cla (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c0,
    output logic [3:0] o_s,
    output logic       o_c4
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p    = i_a ^ i_b;
    assign w_g    = i_a & i_b;
    assign w_c[0] = i_c0;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign o_s    = w_p ^ w_c[3:0];
    assign o_c4   = w_c[4];
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    cla_seq_adder_if.slave    bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_op;

    logic [3:0]       w_a_sl;
    logic [3:0]       w_b_sl;
    logic [3:0]       w_s;
    logic             w_c4;
    logic             w_last;
    logic             w_op_in;

`ifdef CLA_SUB_EN
    assign w_op_in = bus.op;
`else
    assign w_op_in = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert the B slice, carry-in forced at accept time.
    assign w_a_sl = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_sl = r_op ? ~r_b[{r_idx, 2'b00} +: 4] : r_b[{r_idx, 2'b00} +: 4];
    assign w_last = (r_idx == IDXW'(NSLICE - 1));

    adder_4bit_cla u_slice (
        .i_a  (w_a_sl),
        .i_b  (w_b_sl),
        .i_c0 (r_carry),
        .o_s  (w_s),
        .o_c4 (w_c4)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_op       <= w_op_in;
                        r_carry    <= w_op_in ? 1'b1 : bus.cin;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_cout     <= 1'b0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_s;
                    r_carry                    <= w_c4;
                    if (w_last) begin
                        r_cout      <= w_c4;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - randomized self-checking bench for cla_seq_adder
// Exercises op=1 subtraction when CLA_SUB_EN is defined.
module tb_cla_seq_adder;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();
    cla_seq_adder_if #(.WIDTH(4))     bus4 ();

    cla_seq_adder #(.WIDTH(WIDTH)) dut  (.clk(clk), .reset(reset), .bus(bus));
    cla_seq_adder #(.WIDTH(4))     dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic mop);
        int unsigned t;
        if (mop) begin
            t = (int'(ma) >= int'(mb)) ? 32'h1_0000 : 32'h0;
            t = t + ((int'(ma) - int'(mb) + 65536) % 65536);
            return t[16:0];
        end
        t = int'(ma) + int'(mb) + int'(mcin);
        return {t >= 65536, t[15:0]};
    endfunction

    task automatic do_add(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                          input logic top, input int hold, input bit noisy);
        logic [16:0] exp;
        int k;
        exp = model(ta, tb_, tcin, top);
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.a = ta; bus.b = tb_; bus.cin = tcin; bus.in_valid = 1'b1;
`ifdef CLA_SUB_EN
        bus.op = top;
`endif
        @(posedge clk); #1;
        if (!noisy) bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 3 * NSLICE) begin
            if (noisy) begin
                bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
`ifdef CLA_SUB_EN
                bus.op = 1'($urandom);
`endif
            end
            @(posedge clk); #1; k++;
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(k), 32'(NSLICE));
        check("sum", 32'(bus.sum), 32'(exp[15:0]));
        check("cout", 32'(bus.cout), 32'(exp[16]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_sum", 32'(bus.sum), 32'(exp[15:0]));
            check("bp_cout", 32'(bus.cout), 32'(exp[16]));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int k;
        int seen;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
`ifdef CLA_SUB_EN
        bus.op = 1'b0; bus4.op = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        do_add(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        do_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_add(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        do_add(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 10, 1'b0);

        // Abort at idx=2: accept edge, then two RUN edges.
        bus.a = 16'h00FF; bus.b = 16'h0F0F; bus.cin = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("run_busy", 32'(bus.busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        do_add(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        do_add(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 0, 1'b1);

`ifdef CLA_SUB_EN
        do_add(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        do_add(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic rop;
`ifdef CLA_SUB_EN
            rop = 1'($urandom);
`else
            rop = 1'b0;
`endif
            do_add(16'($urandom), 16'($urandom), 1'($urandom), rop,
                   int'($urandom_range(0, 2)), 1'($urandom));
        end

        bus4.a = 4'hF; bus4.b = 4'h1; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        k = 0;
        while (!bus4.out_valid && k < 10) begin
            @(posedge clk); #1; k++;
        end
        check("w4_latency", 32'(k), 32'd1);
        check("w4_sum", 32'(bus4.sum), 32'h0);
        check("w4_cout", 32'(bus4.cout), 32'd1);
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check("w4_idle", 32'(bus4.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
